mux_scan_sel: RTL
=================

# mux_scan_sel

Registered, parametrised N-channel multiplexer that succeeds the combinational 16:1 mux used in the lab datapath. It operates in two modes. In direct mode it drives the selected channel out with one cycle of latency. In scan mode, after a start pulse, it walks every channel in order, one channel per cycle, and tags each output word with its channel index. It sits between a bank of parallel sources and a single serial consumer, such as a display driver or logger.

## Interface
- `WIDTH`, default 1: bits per channel.
- `CHANNELS`, default 16: number of input channels. Must be ≥ 2.
- `SELW`, default 4: select and index width. Must satisfy 2**SELW ≥ CHANNELS.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, CHANNELS*WIDTH: packed channels. Channel k occupies `din[k*WIDTH +: WIDTH]`.
- `mode`, input, 1: 0 = direct, 1 = scan.
- `sel`, input, SELW: channel select, used in direct mode only.
- `start`, input, 1: begins a scan. Acts only in IDLE with `mode`=1.
- `dout`, output, WIDTH: registered selected data.
- `ch`, output, SELW: channel index of the current `dout`.
- `valid`, output, 1: `dout`/`ch` hold a legitimate sample this cycle.
- `done`, output, 1: one-cycle pulse, coincident with the last channel of a scan pass.

## Operation
- **States:** IDLE and SCAN. An internal index counter `idx` is SELW bits wide.
- **Reset:** state = IDLE, `idx` = 0, `dout` = 0, `ch` = 0, `valid` = 0, `done` = 0.
- **Direct mode (`mode`=0), any state:**
  - Each edge captures `dout` ← channel `sel`, `ch` ← `sel`, `valid` ← 1.
  - State goes to IDLE and `done` ← 0.
  - If `sel` ≥ CHANNELS: `dout` ← 0, `ch` ← `sel`, `valid` ← 0.
- **IDLE, `mode`=1, `start`=0:** `dout`/`ch` hold their values, `valid` ← 0, `done` ← 0.
- **IDLE, `mode`=1, `start`=1:** `dout` ← channel 0, `ch` ← 0, `valid` ← 1, `idx` ← 1, state ← SCAN.
- **SCAN, `mode`=1:**
  - Each edge: `dout` ← channel `idx`, `ch` ← `idx`, `valid` ← 1, `idx` ← `idx`+1.
  - `done` ← 1 on the edge that loads channel CHANNELS-1.
  - The following edge returns to IDLE, with `valid` ← 0 and `done` ← 0.
- **`start` during SCAN:** ignored. No restart.
- **`mode` falls to 0 during SCAN:** the scan aborts on that edge, which performs a direct-mode capture. `done` does not pulse.
- **`rst` mid-scan:** overrides everything. All outputs return to their reset values on that edge.
- **Output data:** channel data is passed unmodified. No arithmetic is applied to data. `idx` never exceeds CHANNELS-1 in a registered output.

## Timing
- Direct mode latency is 1 cycle. `dout` at cycle t+1 reflects `din`/`sel` sampled at edge t.
- Scan: `start` sampled at edge t gives channel k on `dout` during cycle t+1+k, for k = 0..CHANNELS-1.
- Scan length is exactly CHANNELS consecutive `valid` cycles with no gaps.
- `done` is high only in cycle t+CHANNELS.
- `valid` is low in cycle t+CHANNELS+1 unless a new `start` is accepted at that edge. `start` is only sampled in IDLE, so the earliest restart is the edge after returning to IDLE.
- `din` is sampled per cycle. A channel changed mid-scan is seen with its value at the edge that loads it.

## Configuration
- **`MUX_SCAN_CONT_EN` defined:** continuous scan. After loading channel CHANNELS-1 (with `done`=1), the next edge loads channel 0 and the block stays in SCAN. `done` pulses once per pass. SCAN exits only on `mode`=0 or `rst`.
- **`MUX_SCAN_CONT_EN` undefined:** single pass per `start`, as described in Operation.

## Test plan
Parameters for all scenarios: WIDTH=1, CHANNELS=16, SELW=4.
- **Reset:** `rst`=1 for 2 cycles while `din`=16'hFFFF, `mode`=1, `start`=1. Required: `dout`=0, `ch`=0, `valid`=0, `done`=0 throughout. After release, the block is in IDLE.
- **Direct mode:**
  - `din`=16'h0001 with `sel`=0, then `din`=16'h0020 with `sel`=5, then `din`=16'h0400 with `sel`=10, then `din`=16'h8000 with `sel`=15, stepping every cycle.
  - Required: `dout`=1 with `ch` = 0, 5, 10, 15, each one cycle after its select, and `valid`=1.
- **Single scan:** `din`=16'hA5C3, `mode`=1, `start` pulsed at edge t. Required: `dout` sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over cycles t+1..t+16, `ch` 0..15, `done` only at t+16, `valid`=0 at t+17.
- **Abort and ignore:**
  - During a scan, pulse `start` at `ch`=3. Required: no restart.
  - Drop `mode` at `ch`=7 with `sel`=2 and `din`=16'h0004. Required: next `dout`=1, `ch`=2, no `done` pulse.
- **Reset mid-scan:** `rst` asserted at `ch`=9. Required: outputs zero on the next edge and state IDLE. A subsequent `start` begins again at `ch`=0.
- **Continuous scan (`MUX_SCAN_CONT_EN` defined):** run 2 passes. Required: `ch` wraps 15→0 with no `valid` gap, and `done` pulses at both wraps.

Source files
------------

// File: rtl/mux_scan_sel.sv
// Registered N-channel mux with direct select and in-order scan modes.
// Define MUX_SCAN_CONT_EN for continuous scanning (wraps instead of returning to IDLE).
module mux_scan_sel #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SELW     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic                      start,
    output logic [WIDTH-1:0]          dout,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      done
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam int unsigned     NCH  = CHANNELS;
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    state_t            state, state_nx;
    logic [SELW-1:0]   idx, idx_nx;
    logic [WIDTH-1:0]  dout_nx;
    logic [SELW-1:0]   ch_nx;
    logic              valid_nx;
    logic              done_nx;

    // Out-of-range selects fall through to zero rather than reading past din.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                              input logic [SELW-1:0] k);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(k) == i) r = d[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            dout  <= '0;
            ch    <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            dout  <= dout_nx;
            ch    <= ch_nx;
            valid <= valid_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dout_nx  = dout;
        ch_nx    = ch;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
        if (!mode) begin
            state_nx = IDLE;
            idx_nx   = '0;
            ch_nx    = sel;
            if (32'(sel) < NCH) begin
                dout_nx  = pick(din, sel);
                valid_nx = 1'b1;
            end else begin
                dout_nx  = '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dout_nx  = pick(din, '0);
                        ch_nx    = '0;
                        valid_nx = 1'b1;
                        idx_nx   = SELW'(1);
                        state_nx = SCAN;
                    end
                end
                SCAN: begin
`ifndef MUX_SCAN_CONT_EN
                    // done high means the last channel was loaded on the previous edge.
                    if (done) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else
`endif
                    begin
                        dout_nx  = pick(din, idx);
                        ch_nx    = idx;
                        valid_nx = 1'b1;
                        if (idx == LAST) begin
                            done_nx = 1'b1;
                            idx_nx  = '0;
                        end else begin
                            idx_nx  = idx + SELW'(1);
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
